// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/dcache main-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_LINE_AW = 28;
    localparam int unsigned MEM_LINE_W  = 128;

    typedef logic [MEM_LINE_W-1:0]  line_t;
    typedef logic [MEM_LINE_AW-1:0] line_addr_t;

    typedef enum logic [2:0] {IDLE, MEM_I, MEM_D, RESP, HOLD} arb_state_t;

    localparam bit ARB_PORT_I = 1'b0;
    localparam bit ARB_PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter.
// master = arbiter view, slave = caches plus memory model.
interface mem_arbiter_if #(
    parameter int unsigned LINE_AW = 28,
    parameter int unsigned LINE_W  = 128
);

    logic               reqI_mem;
    logic [LINE_AW-1:0] reqAddrI_mem;
    logic [LINE_W-1:0]  data_to_icache;
    logic               readyI_mem;

    logic               reqD_mem;
    logic [LINE_AW-1:0] reqAddrD_mem;
    logic               reqD_cache_write;
    logic [LINE_W-1:0]  data_to_mem;
    logic [LINE_W-1:0]  data_from_mem;
    logic               read_ready_from_mem;
    logic               written_data_ack;

    logic               mem_req;
    logic               mem_we;
    logic [LINE_AW-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_ready;

    logic               grant_d;
    logic               err_timeout;

    modport master (
        input  reqI_mem, reqAddrI_mem, reqD_mem, reqAddrD_mem, reqD_cache_write, data_to_mem,
        input  mem_rdata, mem_ready,
        output data_to_icache, readyI_mem, data_from_mem, read_ready_from_mem, written_data_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, grant_d, err_timeout
    );

    modport slave (
        output reqI_mem, reqAddrI_mem, reqD_mem, reqAddrD_mem, reqD_cache_write, data_to_mem,
        output mem_rdata, mem_ready,
        input  data_to_icache, readyI_mem, data_from_mem, read_ready_from_mem, written_data_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, grant_d, err_timeout
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Memory-port watchdog: cleared on grant, counts while a transaction is outstanding.
// TIMEOUT = 0 removes the counter and never expires.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expire
);

    if (TIMEOUT == 0) begin : g_off
        assign expire = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
        localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        // Saturates at TIMEOUT so a stuck run can never wrap back to zero.
        always_comb begin
            cnt_d = cnt_q;
            if (start) begin
                cnt_d = '0;
            end else if (run && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Fires in the TIMEOUT-th outstanding cycle.
        assign expire = run && (cnt_q == CNT_LAST);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache refills and dcache refills/write-backs onto one line-wide memory port.
// Optional MEM_ARB_RR_EN: round-robin on ties instead of fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LINE_AW = MEM_LINE_AW,
    parameter int unsigned LINE_W  = MEM_LINE_W,
    parameter int unsigned TIMEOUT = 64
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.master bus
);

    arb_state_t         state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [LINE_AW-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               owner_q, owner_d;
    logic [LINE_W-1:0]  rdata_i_q, rdata_i_d;
    logic [LINE_W-1:0]  rdata_d_q, rdata_d_d;
    logic               err_q, err_d;

    logic               any_req;
    logic               win_d;
    logic               in_mem;
    logic               wd_start;
    logic               wd_expire;

`ifdef MEM_ARB_RR_EN
    logic               prio_d_q, prio_d_d;
`endif

    assign any_req = bus.reqI_mem || bus.reqD_mem;
    assign in_mem  = (state_q == MEM_I) || (state_q == MEM_D);

`ifdef MEM_ARB_RR_EN
    assign win_d = bus.reqD_mem && (!bus.reqI_mem || prio_d_q);
`else
    assign win_d = bus.reqD_mem;
`endif

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .start  (wd_start),
        .run    (in_mem),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        rdata_i_d   = rdata_i_q;
        rdata_d_d   = rdata_d_q;
        err_d       = err_q;
        wd_start    = 1'b0;
`ifdef MEM_ARB_RR_EN
        prio_d_d    = prio_d_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    wd_start  = 1'b1;
                    mem_req_d = 1'b1;
                    if (win_d) begin
                        owner_d     = ARB_PORT_D;
                        mem_addr_d  = bus.reqAddrD_mem;
                        mem_we_d    = bus.reqD_cache_write;
                        mem_wdata_d = bus.data_to_mem;
                        state_d     = MEM_D;
                    end else begin
                        owner_d     = ARB_PORT_I;
                        mem_addr_d  = bus.reqAddrI_mem;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        state_d     = MEM_I;
                    end
`ifdef MEM_ARB_RR_EN
                    prio_d_d = !win_d;
`endif
                end
            end
            MEM_I, MEM_D: begin
                // A completion in the same cycle as expiry still counts as served.
                if (bus.mem_ready && mem_req_q) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (owner_q == ARB_PORT_I) begin
                        rdata_i_d = bus.mem_rdata;
                    end else if (!mem_we_q) begin
                        rdata_d_d = bus.mem_rdata;
                    end
                end else if (wd_expire) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = HOLD;
                end
            end
            RESP:    state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= ARB_PORT_I;
            rdata_i_q   <= '0;
            rdata_d_q   <= '0;
            err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
            prio_d_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            rdata_i_q   <= rdata_i_d;
            rdata_d_q   <= rdata_d_d;
            err_q       <= err_d;
`ifdef MEM_ARB_RR_EN
            prio_d_q    <= prio_d_d;
`endif
        end
    end

    // Response pulses are decoded from RESP so each transaction yields exactly one.
    assign bus.readyI_mem          = (state_q == RESP) && (owner_q == ARB_PORT_I);
    assign bus.read_ready_from_mem = (state_q == RESP) && (owner_q == ARB_PORT_D) && !mem_we_q;
    assign bus.written_data_ack    = (state_q == RESP) && (owner_q == ARB_PORT_D) && mem_we_q;

    assign bus.data_to_icache = rdata_i_q;
    assign bus.data_from_mem  = rdata_d_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.grant_d        = (state_q == MEM_D);
    assign bus.err_timeout    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
// Honours MEM_ARB_RR_EN the same way as the design build.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.LINE_AW(MEM_LINE_AW), .LINE_W(MEM_LINE_W)) bus ();

    mem_arbiter #(
        .LINE_AW (MEM_LINE_AW),
        .LINE_W  (MEM_LINE_W),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pending cache requests as the caches currently present them.
    bit         pi, pd, wd;
    line_addr_t ai, ad;
    line_t      dd;
    bit         won;

`ifdef MEM_ARB_RR_EN
    bit fav_d;
`endif

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic line_t rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic line_addr_t rand_addr();
        return line_addr_t'($urandom);
    endfunction

    task automatic drive();
        bus.reqI_mem         = pi;
        bus.reqAddrI_mem     = ai;
        bus.reqD_mem         = pd;
        bus.reqAddrD_mem     = ad;
        bus.reqD_cache_write = wd;
        bus.data_to_mem      = dd;
    endtask

    function automatic logic [2:0] pulses();
        return {bus.readyI_mem, bus.read_ready_from_mem, bus.written_data_ack};
    endfunction

    task automatic idle_check(input string tag);
        check_eq({tag, "_mem_req"}, bus.mem_req, 1'b0);
        check_eq({tag, "_pulses"}, pulses(), 3'b000);
    endtask

    task automatic model_reset();
`ifdef MEM_ARB_RR_EN
        fav_d = 1'b1;
`endif
    endtask

    task automatic model_grant(input bit to_d);
`ifdef MEM_ARB_RR_EN
        fav_d = !to_d;
`endif
    endtask

    // Spec rule: single requester wins; on a tie, D (fixed) or the port not granted last (RR).
    function automatic bit model_pick_d();
        if (pi && pd) begin
`ifdef MEM_ARB_RR_EN
            return fav_d;
`else
            return 1'b1;
`endif
        end
        return pd;
    endfunction

    // Called in IDLE with requests driven; the next edge arbitrates.
    task automatic do_round(input string tag, input int lat, input bit perturb,
                            input line_t rdata, output bit won_d);
        line_addr_t exp_addr;
        bit         exp_we;
        line_t      exp_wdata;
        logic [2:0] exp_p;
        won_d     = model_pick_d();
        exp_addr  = won_d ? ad : ai;
        exp_we    = won_d && wd;
        exp_wdata = dd;
        model_grant(won_d);
        tick();
        check_eq({tag, "_req"}, bus.mem_req, 1'b1);
        check_eq({tag, "_grant_d"}, bus.grant_d, won_d);
        check_eq({tag, "_addr"}, bus.mem_addr, exp_addr);
        check_eq({tag, "_we"}, bus.mem_we, exp_we);
        if (exp_we) check_eq({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
        for (int k = 1; k < lat; k++) begin
            if (perturb) begin
                if (won_d) begin
                    ad = rand_addr();
                    dd = rand_line();
                    wd = 1'($urandom_range(1, 0));
                end else begin
                    ai = rand_addr();
                end
                drive();
            end
            tick();
            check_eq({tag, "_hold_req"}, bus.mem_req, 1'b1);
            check_eq({tag, "_hold_addr"}, bus.mem_addr, exp_addr);
            check_eq({tag, "_hold_we"}, bus.mem_we, exp_we);
            check_eq({tag, "_hold_grant"}, bus.grant_d, won_d);
            check_eq({tag, "_hold_pulses"}, pulses(), 3'b000);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = ~rdata;
        exp_p = !won_d ? 3'b100 : (exp_we ? 3'b001 : 3'b010);
        check_eq({tag, "_resp_req"}, bus.mem_req, 1'b0);
        check_eq({tag, "_resp_pulse"}, pulses(), exp_p);
        if (!won_d) check_eq({tag, "_resp_idata"}, bus.data_to_icache, rdata);
        else if (!exp_we) check_eq({tag, "_resp_ddata"}, bus.data_from_mem, rdata);
    endtask

    initial begin
        int cyc;
        pi = 0; pd = 0; wd = 0; ai = '0; ad = '0; dd = '0;
        drive();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst_mem_req", bus.mem_req, 1'b0);
        check_eq("rst_mem_we", bus.mem_we, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, '0);
        check_eq("rst_mem_wdata", bus.mem_wdata, '0);
        check_eq("rst_grant_d", bus.grant_d, 1'b0);
        check_eq("rst_err", bus.err_timeout, 1'b0);
        check_eq("rst_pulses", pulses(), 3'b000);
        check_eq("rst_idata", bus.data_to_icache, '0);
        check_eq("rst_ddata", bus.data_from_mem, '0);
        reset = 1'b1;
        model_reset();
        tick();

        // I-only read, memory answers after 3 cycles.
        pi = 1; ai = 28'h0000040;
        drive();
        do_round("i_read", 3, 1'b0, {16{8'hA5}}, won);
        pi = 0;
        drive();
        tick(); idle_check("i_hold");
        tick(); idle_check("i_idle");

        // D write-back, then same port re-requests a read during RESP.
        pd = 1; wd = 1; ad = 28'h0000100; dd = 128'h12345678_9abcdef0_0fedcba9_87654321;
        drive();
        do_round("d_wb", 2, 1'b0, rand_line(), won);
        wd = 0; ad = 28'h0000080;
        drive();
        tick(); idle_check("wb_hold");
        tick(); idle_check("wb_gap");
        do_round("d_rd", 2, 1'b0, rand_line(), won);
        pd = 0;
        drive();
        tick(); idle_check("rd_hold");
        tick(); idle_check("rd_gap");

        // Completion in the very cycle the watchdog would expire.
        pi = 1; ai = rand_addr();
        drive();
        do_round("lat_max", int'(TO), 1'b1, rand_line(), won);
        check_eq("lat_max_err", bus.err_timeout, 1'b0);
        pi = 0;
        drive();
        tick(); tick();

        // Both ports held high for three rounds, starting from reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        pi = 1; pd = 1; wd = 0; ai = 28'h0000100; ad = 28'h0000200;
        drive();
        for (int r = 0; r < 3; r++) begin
            do_round($sformatf("both%0d", r), 2 + r, 1'b0, rand_line(), won);
            if (won) ad = ad + 28'h10;
            else ai = ai + 28'h10;
            drive();
            tick(); idle_check("both_hold");
            tick(); idle_check("both_gap");
        end
        pi = 0; pd = 0;
        drive();
        tick();

        // Watchdog: D read that memory never answers.
        pd = 1; wd = 0; ad = rand_addr();
        drive();
        model_grant(1'b1);
        tick();
        check_eq("to_req", bus.mem_req, 1'b1);
        check_eq("to_grant", bus.grant_d, 1'b1);
        cyc = 0;
        while (bus.mem_req && cyc < 20) begin
            cyc++;
            check_eq("to_nopulse", pulses(), 3'b000);
            tick();
        end
        check_eq("to_cycles", cyc, TO);
        check_eq("to_err", bus.err_timeout, 1'b1);
        check_eq("to_drop_pulse", pulses(), 3'b000);
        pd = 0;
        drive();
        tick();
        idle_check("to_idle");
        pi = 1; ai = rand_addr();
        drive();
        do_round("after_to", 2, 1'b0, rand_line(), won);
        check_eq("to_sticky", bus.err_timeout, 1'b1);
        pi = 0;
        drive();
        tick(); tick();

        // Reset while MEM_I is outstanding, then a stale mem_ready.
        pi = 1; ai = rand_addr();
        drive();
        tick();
        check_eq("mrst_pre_req", bus.mem_req, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        check_eq("mrst_req", bus.mem_req, 1'b0);
        check_eq("mrst_pulses", pulses(), 3'b000);
        check_eq("mrst_grant", bus.grant_d, 1'b0);
        check_eq("mrst_err", bus.err_timeout, 1'b0);
        check_eq("mrst_addr", bus.mem_addr, '0);
        reset = 1'b1;
        model_reset();
        pi = 0;
        drive();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rand_line();
        tick();
        bus.mem_ready = 1'b0;
        idle_check("late_rdy");
        check_eq("late_idata", bus.data_to_icache, '0);
        tick();
        idle_check("late_rdy2");
        pd = 1; wd = 1; ad = rand_addr(); dd = rand_line();
        drive();
        do_round("post_rst", 1, 1'b0, rand_line(), won);
        pd = 0;
        drive();
        tick(); tick();

        // Random traffic: served port re-requests or drops, loser stays pending.
        for (int r = 0; r < 40; r++) begin
            if (!pi && $urandom_range(1, 0) == 1) begin
                pi = 1; ai = rand_addr();
            end
            if (!pd && $urandom_range(1, 0) == 1) begin
                pd = 1; wd = 1'($urandom_range(1, 0)); ad = rand_addr(); dd = rand_line();
            end
            drive();
            while (!pi && !pd) begin
                tick();
                idle_check("rnd_idle");
                if ($urandom_range(1, 0) == 1) begin
                    pi = 1; ai = rand_addr();
                end else begin
                    pd = 1; wd = 1'($urandom_range(1, 0)); ad = rand_addr(); dd = rand_line();
                end
                drive();
            end
            do_round("rnd", int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)),
                     rand_line(), won);
            if (won) begin
                if ($urandom_range(1, 0) == 1) begin
                    wd = 1'($urandom_range(1, 0)); ad = rand_addr(); dd = rand_line();
                end else begin
                    pd = 0;
                end
            end else begin
                if ($urandom_range(1, 0) == 1) ai = rand_addr();
                else pi = 0;
            end
            drive();
            tick(); idle_check("rnd_hold");
            tick(); idle_check("rnd_gap");
        end
        check_eq("rnd_err", bus.err_timeout, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates between instruction-cache line refills and data-cache line refills/write-backs for the single 128-bit main-memory port.
- Sits between icache/data_cache and the memory model.
- Serves one line transaction at a time through a small FSM and returns a one-cycle response pulse to the owning cache.
- Includes a watchdog that flags a memory port that never answers.

Parameters:
- LINE_AW, 28, line-address width (byte address [31:4]).
- LINE_W, 128, cache-line width in bits.
- TIMEOUT, 64, cycles to wait for mem_ready before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- reqI_mem  in  1  icache line-read request (level, held until its response).
- reqAddrI_mem  in  LINE_AW  icache line address.
- data_to_icache  out  LINE_W  refill data for icache.
- readyI_mem  out  1  one-cycle pulse: icache refill data valid.
- reqD_mem  in  1  dcache request (level, held until its response).
- reqAddrD_mem  in  LINE_AW  dcache line address.
- reqD_cache_write  in  1  1 = write-back of data_to_mem, 0 = line read.
- data_to_mem  in  LINE_W  write-back data.
- data_from_mem  out  LINE_W  refill data for dcache.
- read_ready_from_mem  out  1  one-cycle pulse: dcache refill data valid.
- written_data_ack  out  1  one-cycle pulse: dcache write-back complete.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  LINE_AW  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion pulse.
- grant_d  out  1  1 while the dcache owns the port.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (reset==0 at posedge): FSM to IDLE.
  - Outputs cleared: all pulses/strobes, mem_req, mem_we, grant_d, err_timeout and all data/address outputs go to 0.
  - Priority pointer set to favour D; watchdog counter cleared.
  - Reset mid-transaction drops mem_req the next cycle, with no response pulse.
- FSM states: IDLE, MEM_I, MEM_D, RESP, HOLD.
- IDLE:
  - If any request is pending, arbitrate (see Optional Feature).
  - The winner's address, write flag and write data are latched into mem_addr, mem_we and mem_wdata.
  - mem_req=1 from the next cycle; go to MEM_I or MEM_D; grant_d=1 in MEM_D.
- MEM_x:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable.
  - Request inputs are ignored; changes to the owner's inputs mid-transaction have no effect.
  - On mem_ready: capture mem_rdata, drop mem_req, go to RESP.
- RESP: exactly one pulse, data registered on the same cycle:
  - I read: readyI_mem=1, data_to_icache valid.
  - D read: read_ready_from_mem=1, data_from_mem valid.
  - D write: written_data_ack=1.
  - Then go to HOLD.
- HOLD: one idle cycle. The just-served port is masked so the cache can update req/write. Then go to IDLE.
- Latency:
  - Request seen in IDLE at cycle N gives mem_req high at N+1.
  - mem_ready at cycle M gives the response pulse at M+1.
  - Next arbitration happens at M+3.
- A mem_ready that arrives while mem_req=0 is ignored.
- Simultaneous requests: one grant only; the loser stays pending with its request untouched.
- Watchdog (TIMEOUT>0):
  - Counter runs during MEM_x and resets on each grant.
  - On reaching TIMEOUT with no mem_ready: set err_timeout, drop mem_req, and return to IDLE via HOLD with no response pulse.
  - err_timeout clears only on reset.
- Watchdog counter width is $clog2(TIMEOUT+1); no wrap.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin priority. On a tie, the port not granted last wins; the pointer updates on every grant.
- Undefined: fixed priority, D always beats I. An I request can starve while D keeps requesting.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, MEM_I, MEM_D, RESP, HOLD};
  - typedef line_t (LINE_W bits) and line_addr_t (LINE_AW bits);
  - localparam ARB_PORT_I=0, ARB_PORT_D=1.
- One natural sub-module: mem_arb_watchdog, the timeout counter with start/clear/expire.

Test Plan:
- I-only read:
  - Stimulus: reqI_mem=1, reqAddrI_mem=0x0000040; memory returns 0xA5A5...A5 after 3 cycles.
  - Required: mem_we=0, mem_addr=0x0000040, a single readyI_mem pulse with that data, grant_d=0 throughout.
- D write-back then D read:
  - Stimulus: reqD_mem=1, reqD_cache_write=1, data_to_mem=0x1234...; after the ack the cache drops write and keeps req with addr 0x0000080.
  - Required: one written_data_ack, one HOLD cycle, then mem_we=0, mem_addr=0x0000080, read_ready_from_mem pulse.
- Simultaneous I and D from reset:
  - With MEM_ARB_RR_EN: D first, then I, then D on three rounds of both held high.
  - Without MEM_ARB_RR_EN: D served every round, I never granted.
- Timeout:
  - Stimulus: TIMEOUT=8, D read, mem_ready never arrives.
  - Required: mem_req drops after 8 cycles, err_timeout=1 sticky, no response pulse, next request still served.
- Reset mid-transaction:
  - Stimulus: reset=0 while in MEM_I.
  - Required: next cycle mem_req=0, all pulses 0, FSM in IDLE, and a late mem_ready is ignored.
